mux_scan_ctrl: RTL and testbench

- Sequential scanner that drives the 2-bit select `s` of the downstream 4:1 one-bit mux and samples its output `y` back.
- Each scan steps `s` through 0,1,2,3, samples `y` once per step, and assembles the four samples into a 4-bit word `q`, rebuilding the mux data input.
- Used as the control and readback stage beside the mux in the board-level sim top.
- Supports single-shot or continuous scans, with a programmable settle delay per step.

---
 rtl/mux_scan_ctrl_pkg.sv | 14 +
 rtl/mux_scan_ctrl_settle_cnt.sv | 28 ++
 rtl/mux_scan_ctrl.sv | 102 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan controller: FSM state encoding and scan length.
package mux_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SET    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } scan_state_t;

  localparam logic [1:0] LAST_IDX = 2'd3;

endpackage

// File: rtl/mux_scan_ctrl_settle_cnt.sv
// Loadable down-counter that times the settle period of each scan step.
module scan_settle_cnt #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [DIV_W-1:0] val,
  output logic             zero
);

  logic [DIV_W-1:0] cnt_reg;

  // Decrement is gated on nonzero so the counter can never underflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps a 4:1 mux select through 0..3, samples its output each step and
// reassembles the four samples into q; single-shot or continuous scans.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic [DIV_W-1:0] div,
  input  logic             y,
  output logic [1:0]       s,
  output logic             busy,
  output logic             done,
  output logic [3:0]       q
);

  scan_state_t      state_reg;
  logic [1:0]       idx_reg;
  logic [1:0]       s_reg;
  logic [DIV_W-1:0] div_q_reg;
  logic [3:0]       shadow_reg;
  logic [3:0]       q_reg;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;

  assign cnt_load = (state_reg == ST_SET);
  assign cnt_dec  = (state_reg == ST_WAIT) && !cnt_zero;

  scan_settle_cnt #(
    .DIV_W (DIV_W)
  ) u_settle (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .val  (div_q_reg),
    .zero (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= '0;
      s_reg      <= '0;
      div_q_reg  <= '0;
      shadow_reg <= '0;
      q_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          s_reg <= '0;
          if (start) begin
            div_q_reg  <= div;
            idx_reg    <= '0;
            shadow_reg <= '0;
            state_reg  <= ST_SET;
          end
        end
        ST_SET: begin
          s_reg     <= idx_reg;
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_zero) state_reg <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          shadow_reg[idx_reg] <= y;
          if (idx_reg == LAST_IDX) begin
            q_reg     <= {y, shadow_reg[2:0]};
            state_reg <= ST_DONE;
          end else begin
            idx_reg   <= idx_reg + 2'd1;
            state_reg <= ST_SET;
          end
        end
        ST_DONE: begin
          // Continuous mode relatches div and rescans with no idle gap.
          if (cont) begin
            idx_reg    <= '0;
            shadow_reg <= '0;
            div_q_reg  <= div;
            state_reg  <= ST_SET;
          end else begin
            s_reg     <= '0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign s    = s_reg;
  assign q    = q_reg;
  assign busy = (state_reg != ST_IDLE);
  assign done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized self-checking bench: the DUT scans a behavioural 4:1 mux and is
// compared cycle by cycle against timing computed from the scan rules.
module tb_mux_scan_ctrl;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             cont;
  logic [DIV_W-1:0] div;
  logic             y;
  logic [1:0]       s;
  logic             busy;
  logic             done;
  logic [3:0]       q;
  logic [3:0]       a;
  logic [3:0]       prev_q;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign y = a[s];

  mux_scan_ctrl #(
    .DIV_W (DIV_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .cont  (cont),
    .div   (div),
    .y     (y),
    .s     (s),
    .busy  (busy),
    .done  (done),
    .q     (q)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected select in cycle t of a single scan started in cycle 0.
  function automatic logic [31:0] exp_s(input int t, input int dv);
    int per;
    int last;
    int k;
    int pos;
    per  = 3 + dv;
    last = 1 + 4 * per;
    if (t < 1 || t > last) return 0;
    if (t == last) return 3;
    k   = (t - 1) / per;
    pos = (t - 1) % per;
    if (pos == 0) return (k == 0) ? 0 : k - 1;
    return k;
  endfunction

  task automatic scan_once(input int dv, input logic [3:0] av, input int chg_t, input int dv_new);
    int last;
    a     = av;
    div   = DIV_W'(dv);
    cont  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    last  = 1 + 4 * (3 + dv);
    for (int t = 1; t <= last + 1; t++) begin
      if (t == chg_t) div = DIV_W'(dv_new);
      check("s",    32'(s),    exp_s(t, dv));
      check("busy", 32'(busy), 32'(t <= last));
      check("done", 32'(done), 32'(t == last));
      check("q",    32'(q),    32'((t >= last) ? av : prev_q));
      tick();
    end
    prev_q = av;
    $display("scan div=%0d a=%b q=%b done_cycle=%0d", dv, av, q, last);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; div = '0; a = 4'b1010; prev_q = 4'b0000;
    tick();
    tick();
    check("rst_s",    32'(s),    0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_q",    32'(q),    0);
    rst = 1'b0;
    tick();

    scan_once(0, 4'b1010, 0, 0);
    scan_once(2, 4'b1010, 0, 0);

    // Continuous: done every 13 cycles, busy never drops, new data in scan 2.
    a = 4'b1010; div = '0; cont = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 27; t++) begin
      check("c_done", 32'(done), 32'(t == 13 || t == 26));
      check("c_busy", 32'(busy), 32'(t <= 26));
      if (t == 13) begin
        check("c_q1", 32'(q), 32'(4'b1010));
        a = 4'b0110;
      end
      if (t == 26) check("c_q2", 32'(q), 32'(4'b0110));
      if (t == 20) cont = 1'b0;
      tick();
    end
    prev_q = 4'b0110;
    $display("scan cont q=%b", q);

    // start held high: ignored in DONE, rescan from IDLE.
    a = 4'b1010; start = 1'b1;
    tick();
    for (int t = 1; t <= 30; t++) begin
      check("h_done", 32'(done), 32'(t == 13 || t == 27));
      tick();
    end
    start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    prev_q = 4'b0000;
    $display("scan held-start q=%b", q);

    // Reset mid-scan.
    scan_once(0, 4'b1010, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t < 7; t++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_s",    32'(s),    0);
    check("mr_busy", 32'(busy), 0);
    check("mr_q",    32'(q),    0);
    for (int t = 0; t < 20; t++) begin
      check("mr_done", 32'(done), 0);
      tick();
    end
    prev_q = 4'b0000;
    $display("scan reset-mid q=%b", q);

    // div changed mid-scan takes effect only on the next scan.
    scan_once(0, 4'b1010, 4, 5);
    scan_once(5, 4'b1010, 0, 0);

    for (int i = 0; i < 6; i++) begin
      scan_once(int'($urandom_range(0, 4)), 4'($urandom_range(0, 15)), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
